ropuf_response_gen: RTL

Response side of the ring-oscillator PUF. It drives the `round`/`count` schedule that the challenge shifter consumes, and takes back the 8-bit RO-pair select. For each of 16 rounds it counts rising edges of the two selected ring oscillators over a fixed window, compares the counts, and assembles a 16-bit response word. The response feeds the PUF key-generation path upstream of the AES key schedule.

---
 rtl/ropuf_response_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ropuf_response_gen.sv
// Ring-oscillator PUF response generator: sequences 16 rounds of 256 cycles,
// counts rising edges on the selected RO pair inside a window, and assembles
// a 16-bit response word from the per-round comparisons.
// Optional feature macro: ROPUF_TIE_MASK_EN (builds the per-round equality flag).
module ropuf_response_gen #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned SETTLE     = 16,
  parameter int unsigned WINDOW_END = 240
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [15:0] ro_osc,
  input  logic [7:0]  sel,
  output logic [3:0]  round,
  output logic [7:0]  count,
  output logic        busy,
  output logic        done,
  output logic [15:0] response,
  output logic [15:0] tie_mask
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       SETTLE_C = 8'(SETTLE);
  localparam logic [7:0]       WEND_C   = 8'(WINDOW_END);

  state_e            state_q, state_d;
  logic [3:0]        round_q, round_d;
  logic [7:0]        count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       resp_q, resp_d;
  logic [15:0]       tie_q, tie_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
  logic [15:0]       sync1_q, sync2_q, hist_q;
  logic [15:0]       edge_c;
  logic              edge_a_c, edge_b_c;

  // Two-flop synchroniser plus history flop per oscillator
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= ro_osc;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_c   = sync2_q & ~hist_q;
  assign edge_a_c = edge_c[sel[7:4]];
  assign edge_b_c = edge_c[sel[3:0]];

  // Round/count schedule, counters and per-round compare
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    count_d = count_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;

    unique case (state_q)
      S_IDLE: begin
        round_d = 4'd0;
        count_d = 8'd0;
        if (start) begin
          state_d = S_RUN;
          resp_d  = '0;
          tie_d   = '0;
        end
      end
      S_RUN: begin
        count_d = count_q + 8'd1;
        if (count_q == 8'hFF) begin
          if (round_q == 4'hF) state_d = S_DONE;
          else                 round_d = round_q + 4'd1;
        end
        if (count_q == WEND_C) begin
          resp_d[round_q] = (cnt_a_q > cnt_b_q);
`ifdef ROPUF_TIE_MASK_EN
          tie_d[round_q]  = (cnt_a_q == cnt_b_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        round_d = 4'd0;
        count_d = 8'd0;
      end
      default: state_d = S_IDLE;
    endcase

`ifndef ROPUF_TIE_MASK_EN
    tie_d = '0;
`endif

    // Counters: cleared during settle, saturating count inside window, frozen after
    if (count_q < SETTLE_C) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else if (count_q < WEND_C) begin
      if (edge_a_c && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (edge_b_c && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      round_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
      tie_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign round    = round_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = resp_q;
  assign tie_mask = tie_q;

endmodule
